// File: rtl/step_profile_sequencer.sv
// Trapezoidal step/dir sequencer for one stepper axis.
// One move per command: ACCEL (a intervals), CRUISE (C intervals), DECEL (a intervals).
// Each interval raises STEP for PULSE_W cycles and lasts max(delay, 2*PULSE_W) cycles.
module step_profile_sequencer #(
   parameter int W       = 32,
   parameter int PULSE_W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] n_steps,
   input  logic [W-1:0] accel_steps,
   input  logic [W-1:0] t0,
   input  logic [W-1:0] tna,
   input  logic [W-1:0] delta,
   input  logic         dir_in,
   input  logic         abort,
   output logic         step,
   output logic         dir,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [W-1:0] steps_done,
   output logic [2:0]   phase
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ACCEL  = 3'd2,
      ST_CRUISE = 3'd3,
      ST_DECEL  = 3'd4
   } state_t;

   localparam logic [W-1:0] ZERO_C = {W{1'b0}};
   localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] PW_C   = W'(PULSE_W);
   localparam logic [W-1:0] MIN_C  = W'(2 * PULSE_W);

   // base - dec*k, saturating at zero instead of wrapping
   function automatic logic [W-1:0] sat_delay(input logic [W-1:0] base,
                                              input logic [W-1:0] dec,
                                              input logic [W-1:0] k);
      logic [2*W-1:0] prod;
      prod = {{W{1'b0}}, dec} * {{W{1'b0}}, k};
      if (prod >= {{W{1'b0}}, base}) begin
         return ZERO_C;
      end else begin
         return base - prod[W-1:0];
      end
   endfunction

   // Interval length never shorter than two pulse widths
   function automatic logic [W-1:0] clamp_delay(input logic [W-1:0] d);
      return (d < MIN_C) ? MIN_C : d;
   endfunction

   function automatic logic is_active(input state_t s);
      return (s == ST_ACCEL) || (s == ST_CRUISE) || (s == ST_DECEL);
   endfunction

   state_t         state_r, state_s;
   logic [W-1:0]   n_r, nn_r, t0_r, tna_r, delta_r;
   logic [W-1:0]   idx_r, idx_s, rem_r, rem_s, len_r, len_s, el_r, el_s;
   logic [W-1:0]   a_s, c_s, cd_s, steps_done_r, steps_done_s;
   logic           long_s, ivl_end_s, start_s, accept_s, abort_hit_s;
   logic           step_r, step_s, dir_r, dir_s, busy_r, busy_s;
   logic           done_r, done_s, aborted_r, aborted_s, ready_r, ready_s;

   assign cmd_ready  = ready_r;
   assign step       = step_r;
   assign dir        = dir_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign aborted    = aborted_r;
   assign steps_done = steps_done_r;
   assign phase      = state_r;

   // Move plan (accel count, cruise count, cruise delay) from the latched command
   always_comb begin
      long_s = ({1'b0, n_r} > {nn_r, 1'b0});
      if (long_s) begin
         a_s  = nn_r;
         c_s  = n_r - {nn_r[W-2:0], 1'b0};
         cd_s = tna_r;
      end else begin
         a_s  = {1'b0, n_r[W-1:1]};
         c_s  = {{(W-1){1'b0}}, n_r[0]};
         cd_s = sat_delay(t0_r, delta_r, a_s);
      end
      ivl_end_s = (el_r == (len_r - ONE_C));
   end

   // State register plus all registered outputs and datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         n_r          <= ZERO_C;
         nn_r         <= ZERO_C;
         t0_r         <= ZERO_C;
         tna_r        <= ZERO_C;
         delta_r      <= ZERO_C;
         idx_r        <= ZERO_C;
         rem_r        <= ZERO_C;
         len_r        <= ZERO_C;
         el_r         <= ZERO_C;
         steps_done_r <= ZERO_C;
         step_r       <= 1'b0;
         dir_r        <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         aborted_r    <= 1'b0;
         ready_r      <= 1'b1;
      end else begin
         state_r      <= state_s;
         if (accept_s) begin
            n_r     <= n_steps;
            nn_r    <= accel_steps;
            t0_r    <= t0;
            tna_r   <= tna;
            delta_r <= delta;
         end
         idx_r        <= idx_s;
         rem_r        <= rem_s;
         len_r        <= len_s;
         el_r         <= el_s;
         steps_done_r <= steps_done_s;
         step_r       <= step_s;
         dir_r        <= dir_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
         aborted_r    <= aborted_s;
         ready_r      <= ready_s;
      end
   end

   // Next-state: phase sequencing at interval boundaries; abort overrides boundaries
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) state_s = ST_LOAD;
            else           state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (abort)             state_s = ST_IDLE;
            else if (a_s != ZERO_C) state_s = ST_ACCEL;
            else if (c_s != ZERO_C) state_s = ST_CRUISE;
            else                   state_s = ST_IDLE;
         end
         ST_ACCEL: begin
            if (abort)                  state_s = ST_IDLE;
            else if (!ivl_end_s)        state_s = ST_ACCEL;
            else if (rem_r != ZERO_C)   state_s = ST_ACCEL;
            else if (c_s != ZERO_C)     state_s = ST_CRUISE;
            else                        state_s = ST_DECEL;
         end
         ST_CRUISE: begin
            if (abort)                  state_s = ST_IDLE;
            else if (!ivl_end_s)        state_s = ST_CRUISE;
            else if (rem_r != ZERO_C)   state_s = ST_CRUISE;
            else if (a_s != ZERO_C)     state_s = ST_DECEL;
            else                        state_s = ST_IDLE;
         end
         ST_DECEL: begin
            if (abort)                  state_s = ST_IDLE;
            else if (!ivl_end_s)        state_s = ST_DECEL;
            else if (rem_r != ZERO_C)   state_s = ST_DECEL;
            else                        state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Outputs and interval datapath for the next cycle
   always_comb begin
      accept_s    = (state_r == ST_IDLE) && cmd_valid;
      abort_hit_s = (state_r != ST_IDLE) && abort;
      start_s     = is_active(state_s) && ((state_r == ST_LOAD) || ivl_end_s);
      idx_s       = idx_r;
      rem_s       = rem_r;
      len_s       = len_r;
      if (start_s) begin
         case (state_s)
            ST_ACCEL: begin
               if (state_r == ST_ACCEL) begin
                  idx_s = idx_r + ONE_C;
                  rem_s = rem_r - ONE_C;
               end else begin
                  idx_s = ZERO_C;
                  rem_s = a_s - ONE_C;
               end
               len_s = clamp_delay(sat_delay(t0_r, delta_r, idx_s));
            end
            ST_CRUISE: begin
               if (state_r == ST_CRUISE) rem_s = rem_r - ONE_C;
               else                      rem_s = c_s - ONE_C;
               len_s = clamp_delay(cd_s);
            end
            ST_DECEL: begin
               if (state_r == ST_DECEL) begin
                  idx_s = idx_r - ONE_C;
                  rem_s = rem_r - ONE_C;
               end else begin
                  idx_s = a_s - ONE_C;
                  rem_s = a_s - ONE_C;
               end
               len_s = clamp_delay(sat_delay(t0_r, delta_r, idx_s));
            end
            default: begin
               idx_s = idx_r;
               rem_s = rem_r;
               len_s = len_r;
            end
         endcase
         el_s = ZERO_C;
      end else if (is_active(state_s)) begin
         el_s = el_r + ONE_C;
      end else begin
         el_s = ZERO_C;
      end
      step_s = is_active(state_s) && (el_s < PW_C);
      if (accept_s)     steps_done_s = ZERO_C;
      else if (start_s) steps_done_s = steps_done_r + ONE_C;
      else              steps_done_s = steps_done_r;
      if (accept_s)         aborted_s = 1'b0;
      else if (abort_hit_s) aborted_s = 1'b1;
      else                  aborted_s = aborted_r;
      dir_s   = accept_s ? dir_in : dir_r;
      done_s  = (state_r != ST_IDLE) && (state_s == ST_IDLE);
      busy_s  = (state_s != ST_IDLE);
      ready_s = (state_s == ST_IDLE);
   end

endmodule
